// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling, optional payload re-inversion,
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLOCK_SPEED    = 50_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int BAUD_WIDTH     = CLOCK_SPEED / BAUD_RATE,
  parameter int HALF_WIDTH     = BAUD_WIDTH / 2,
  parameter bit INVERT_PAYLOAD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_ready,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CNT_W = $clog2(BAUD_WIDTH);
  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(HALF_WIDTH - 1);
  localparam logic [CNT_W-1:0] BAUD_TERM = CNT_W'(BAUD_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       payload;
  logic             rx_m, rx_s;

  // rx is asynchronous; both stages reset to the idle level so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign payload = INVERT_PAYLOAD ? ~shreg : shreg;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rd_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_TERM) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state   <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BAUD_TERM) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BAUD_TERM) begin
            cnt <= '0;
            if (rx_s) begin
              // back to IDLE at the stop midpoint so an immediate next start edge is caught
              state <= IDLE;
              if (!rx_valid || rd_ready) begin
                data     <= payload;
                rx_valid <= 1'b1;
              end else begin
                overrun  <= 1'b1;
              end
            end else begin
              state     <= WAIT_HIGH;
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: directed frames queued as expected bytes,
// monitors pop on each handshake and tally flag pulses.
module tb_uart_rx;
  localparam int BW = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1, rx2 = 1'b1;
  logic       rd_ready = 1'b1;
  logic       rd_ready2 = 1'b1;
  logic [7:0] data, data2;
  logic       rx_valid, frame_err, overrun, busy;
  logic       rx_valid2, frame_err2, overrun2, busy2;

  int total = 0, bad = 0;
  int cyc = 0, fall_cyc = 0, rise_cyc = 0;
  int rise_cnt = 0, vhi = 0, fe_cnt = 0, fe_hi = 0, ov_cnt = 0, ov_hi = 0;
  logic prev_valid = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.INVERT_PAYLOAD(1'b1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_ready(rd_ready), .data(data),
    .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun), .busy(busy));

  uart_rx #(.INVERT_PAYLOAD(1'b0)) dut2 (
    .clk(clk), .rst(rst), .rx(rx2), .rd_ready(rd_ready2), .data(data2),
    .rx_valid(rx_valid2), .frame_err(frame_err2), .overrun(overrun2), .busy(busy2));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input bit sel2);
    if (sel2) rx2 = v;
    else      rx  = v;
  endtask

  // line_bits are the raw levels on the wire, LSB first
  task automatic send_frame(input logic [7:0] line_bits, input logic stop_b, input bit sel2);
    drive(1'b0, sel2);
    fall_cyc = cyc;
    tick(BW);
    for (int i = 0; i < 8; i++) begin
      drive(line_bits[i], sel2);
      tick(BW);
    end
    drive(stop_b, sel2);
    tick(BW);
  endtask

  // main DUT monitor: scoreboard pops on every accepted byte
  always @(negedge clk) begin
    logic [7:0] e;
    if (rx_valid) vhi++;
    if (rx_valid && !prev_valid) begin
      rise_cyc = cyc;
      rise_cnt++;
    end
    prev_valid = rx_valid;
    if (frame_err) fe_hi++;
    if (frame_err && !prev_fe) fe_cnt++;
    prev_fe = frame_err;
    if (overrun) ov_hi++;
    if (overrun && !prev_ov) ov_cnt++;
    prev_ov = overrun;
    if (rx_valid && rd_ready && !rst) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %02h required none", data);
      end else begin
        e = exp_q.pop_front();
        if (data !== e) begin
          bad++;
          $display("FAIL sb_data: got %02h required %02h", data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (rx_valid2 && rd_ready2 && !rst) begin
      total++;
      if (exp2_q.size() == 0) begin
        bad++;
        $display("FAIL sb2_unexpected: got %02h required none", data2);
      end else begin
        e = exp2_q.pop_front();
        if (data2 !== e) begin
          bad++;
          $display("FAIL sb2_data: got %02h required %02h", data2, e);
        end
      end
    end
  end

  initial begin
    int r0, v0, fe0, ov0;

    // reset state
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    tick(20);

    // 0xA5 from an inverting transmitter, with latency and 1-cycle valid
    v0 = vhi;
    exp_q.push_back(8'hA5);
    send_frame(~8'hA5, 1'b1, 1'b0);
    tick(20);
    check("a5_latency", rise_cyc - fall_cyc, 4126);
    check("a5_valid_cycles", vhi - v0, 1);
    check("a5_ferr", fe_cnt, 0);
    check("a5_ovr", ov_cnt, 0);

    // non-inverting instance sees raw 0x3C
    exp2_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1);
    tick(20);
    check("raw_3c_drained", exp2_q.size(), 0);

    // start glitch: 100 cycles low
    r0 = rise_cnt;
    drive(1'b0, 1'b0);
    tick(100);
    check("glitch_busy_mid", busy, 1);
    drive(1'b1, 1'b0);
    tick(150);
    check("glitch_busy_after", busy, 0);
    check("glitch_no_valid", rise_cnt, r0);
    check("glitch_no_ferr", fe_cnt, 0);
    check("glitch_no_ovr", ov_cnt, 0);

    // stop bit low then line held low
    send_frame(~8'h55, 1'b0, 1'b0);
    tick(2000);
    check("brk_busy_low", busy, 1);
    check("brk_ferr_once", fe_cnt, 1);
    check("brk_ferr_width", fe_hi, 1);
    check("brk_no_valid", rise_cnt, r0);
    drive(1'b1, 1'b0);
    tick(10);
    check("brk_busy_release", busy, 0);
    exp_q.push_back(8'h12);
    send_frame(~8'h12, 1'b1, 1'b0);
    tick(20);
    check("after_brk_drained", exp_q.size(), 0);

    // back-to-back with consumer stalled -> overrun on the second
    rd_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(~8'h11, 1'b1, 1'b0);
    send_frame(~8'h22, 1'b1, 1'b0);
    tick(20);
    check("ovr_once", ov_cnt - ov0, 1);
    check("ovr_width", ov_hi, ov_cnt);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", data, 8'h11);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_dropped", rx_valid, 0);
    check("ovr_drained", exp_q.size(), 0);
    rd_ready = 1'b1;
    tick(20);

    // reset during payload bit 4 of 0xF0; link returns to idle with the reset
    r0 = rise_cnt;
    fe0 = fe_cnt;
    drive(1'b0, 1'b0);
    tick(BW);
    for (int i = 0; i < 4; i++) begin
      drive(~8'hF0 >> i, 1'b0);
      tick(BW);
    end
    drive(1'b0, 1'b0);
    tick(200);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    drive(1'b1, 1'b0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_data", data, 8'h00);
    check("midrst_valid", rx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_ovr", overrun, 0);
    tick(BW);
    check("midrst_no_valid", rise_cnt, r0);
    exp_q.push_back(8'h81);
    send_frame(~8'h81, 1'b1, 1'b0);
    tick(20);
    check("midrst_81_drained", exp_q.size(), 0);
    check("midrst_no_ferr", fe_cnt, fe0);
    check("dut2_quiet_ferr", frame_err2 | overrun2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the UART transmitter on the serial line. It recovers 8N1 frames (one start bit low, 8 payload bits LSB first, one stop bit high) at a fixed baud rate by sampling each bit at its midpoint. The line payload is bit-inverted by the transmitter, and this block re-inverts it, so a byte sent is the byte delivered. Each received byte is held in a one-entry valid/ready output register for the downstream consumer, with framing-error and overrun reporting.

## Interface
- CLOCK_SPEED, 50_000_000: clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bit/s.
- BAUD_WIDTH, CLOCK_SPEED/BAUD_RATE (integer truncation, 434): clock cycles per bit.
- HALF_WIDTH, BAUD_WIDTH/2 (truncation, 217): cycles from start-edge detection to the start-bit midpoint.
- INVERT_PAYLOAD, 1: when 1, the delivered byte is the bitwise complement of the line bits.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous and active-high.
- rx  in  1  serial line, asynchronous to clk, idles high.
- rd_ready  in  1  consumer accepts `data` this cycle when `rx_valid` is also high.
- data  out  8  received byte; stable while `rx_valid` is high.
- rx_valid  out  1  a byte is held in `data`.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a good frame is dropped because the holding register is full.
- busy  out  1  high whenever the state is not IDLE (combinational decode of state).

## Operation
- Input synchronizer: `rx` passes through 2 flops, both reset to 1. The output is `rx_s`, and all decisions use `rx_s`.
- Bit counter: width is ceil(log2(BAUD_WIDTH)) bits. It resets to 0 on every state entry. A sample point is the cycle where the counter equals its terminal value.
- IDLE: counter held at 0. If `rx_s`==0, go to START.
- START: count 0..HALF_WIDTH-1. At the terminal count:
  - `rx_s`==0: go to DATA, bit_idx=0.
  - `rx_s`==1: treat as a glitch and return to IDLE. No flags are raised.
- DATA: count 0..BAUD_WIDTH-1. At each terminal count:
  - Shift `rx_s` into the MSB of an 8-bit shift register (shift right), so the first bit received ends up as bit 0.
  - Increment bit_idx. After the 8th sample, go to STOP.
- STOP: count 0..BAUD_WIDTH-1. At the terminal count:
  - `rx_s`==1: the frame is good. Deliver the shift register (complemented if INVERT_PAYLOAD) to the holding logic and go to IDLE. IDLE is entered at the stop-bit midpoint, so a back-to-back start bit is detected.
  - `rx_s`==0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This covers line break and stuck-low conditions.
- Holding register behaviour:
  - On a good frame with `rx_valid`==0: load `data` and set `rx_valid`.
  - When `rx_valid` && `rd_ready`: clear `rx_valid`.
  - On a good frame while `rx_valid` && `rd_ready` in the same cycle: load the new byte. `rx_valid` stays 1 and there is no overrun.
  - On a good frame while `rx_valid` && !`rd_ready`: keep the old byte, drop the new one, and pulse `overrun`.
- Reset:
  - State goes to IDLE; counter, bit_idx and shift register go to 0; synchronizer flops go to 1.
  - Outputs: `data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - Reset during a frame aborts it with no flags. The partial frame's remaining bits may then be mis-detected as a new start bit.

## Timing
- Let t0 be the first cycle in which `rx_s`==0 while in IDLE. The pin fell 2 cycles earlier.
  - START is entered at t0+1.
  - The start midpoint check is at t0+HALF_WIDTH.
  - Payload bit k (0..7) is sampled at t0+HALF_WIDTH+(k+1)·BAUD_WIDTH.
  - The stop bit is sampled at t0+HALF_WIDTH+9·BAUD_WIDTH.
  - `rx_valid`, `frame_err` or `overrun` is registered high on the following cycle.
- With defaults, `rx_valid` rises 4124 cycles after t0, i.e. 4126 cycles after the pin edge.
- `frame_err` and `overrun` are high for exactly 1 cycle.
- `rx_valid` is held until the handshake. `data` changes only on a load.
- Sampling is at mid-bit, so ±(HALF_WIDTH-1) cycles of cumulative skew over a frame is tolerated.

## Test plan
- Loopback from the transmitter, sending 0xA5 with rd_ready=1 -> `data`=0xA5 and `rx_valid` high for 1 cycle at pin-edge+4126. No flags.
- INVERT_PAYLOAD=0; bench drives raw line bits 0x3C LSB first at 434 cycles/bit -> `data`=0x3C.
- Line low for 100 cycles, then high -> back to IDLE after the midpoint check at t0+217. `rx_valid`, `frame_err` and `overrun` stay 0.
- Frame 0x55 with the stop bit driven low, line held low 2000 more cycles -> `frame_err` pulses once, no `rx_valid`, `busy` stays high until the line returns high. A following 0x12 frame is received correctly.
- Two back-to-back frames 0x11, 0x22 with rd_ready=0 -> `data`=0x11 held and `overrun` pulses at the second stop sample. Raising rd_ready for 1 cycle then drops `rx_valid`.
- Assert rst for 1 cycle during payload bit 4 of frame 0xF0 -> all outputs at reset values and no `rx_valid`. After the line idles 1 bit time, a full frame 0x81 gives `data`=0x81.
